decode_sequencer: RTL and testbench
===================================

Name: decode_sequencer

Overview:
- Parametrised, sequential successor to the combinational instruction decoder.
- Accepts one 16-bit instruction through a valid/ready handshake and registers its decoded fields.
- Walks a multi-beat operation one lane per cycle, driving lane index and first/last markers to the vector/scalar datapath.
- Sits between the fetch stage and the register files / memory interface; it replaces external cycle counting.

Parameters:
- VLEN, 16, vector lanes; beats per vector op (must be ≥2).
- RAW, 3, register address width (addr fields are instr[11:9], [8:6], [5:3] when RAW=3).
- OFF_W, 6, offset field width (instr[OFF_W-1:0]).
- IMM_W, 8, immediate field width (instr[IMM_W-1:0]).
- LW, $clog2(VLEN+1), lane counter width (derived localparam).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction offered
- instr  in  16  instruction word
- instr_ready  out  1  sequencer can accept this cycle
- beat_valid  out  1  decoded outputs valid this cycle
- functype  out  4  opcode of the active op
- v_en  out  1  vector register file enable
- s_en  out  1  scalar register file enable
- addr1  out  RAW  source 1
- addr2  out  RAW  source 2
- dstAddr  out  RAW  destination
- offset  out  OFF_W  memory offset
- immediate  out  IMM_W  scalar immediate
- lane  out  LW  current beat index
- first  out  1  first beat of the op
- last  out  1  final beat of the op
- busy  out  1  op in progress (state EXEC)

Behaviour:
- **Reset** (rst=1 at a clk edge): state=IDLE. All outputs 0, except instr_ready=1 in the following cycle. Reset overrides any in-flight op; no further beats are issued.
- **States:**
  - IDLE: instr_ready=1, beat_valid=0, all field outputs 0.
  - EXEC: beat_valid=1, busy=1.
- **Accept:** occurs when instr_valid && instr_ready at a clk edge.
  - Fields and beat total are registered at that edge.
  - The first beat appears the next cycle with lane=0, first=1 (latency 1).
- **instr_ready** = IDLE || (EXEC && last). This allows back-to-back ops with no bubble.
  - When accepted on a last beat, the next cycle is beat 0 of the new op.
  - When not accepted on a last beat, the next cycle is IDLE.
- **Opcode decode and beat count:**
  - VADD 0000: v_en; addr1=[8:6], addr2=[5:3], dst=[11:9]; VLEN beats.
  - VDOT 0001: v_en, s_en; same field mapping as VADD; VLEN beats.
  - SMUL 0010: v_en, s_en; addr1=[8:6] vector, addr2=[5:3] scalar, dst=[11:9]; VLEN beats.
  - SST 0011: s_en; addr1=[8:6], dst=[11:9], offset; 1 beat.
  - VLD 0100: v_en; addr1=[8:6], dst=[11:9], offset; VLEN+1 beats (extra read-latency beat).
  - VST 0101: v_en; addr1=[8:6], dst=[11:9], offset; VLEN beats.
  - SLL 0110 / SLH 0111: s_en; addr1=dst=[11:9], immediate; 1 beat.
  - NOP 1111 and undefined codes 1000–1110: accepted, 1 beat. beat_valid=1 with functype shown, v_en=s_en=0, all other field outputs 0.
- **Unused fields** for an opcode are 0 for the whole op.
- **Field stability:** field outputs are constant across all beats of an op.
- **Beat markers:**
  - lane increments by 1 per beat and does not wrap within an op.
  - last=1 when lane == total-1.
  - For a 1-beat op, first=last=1 in the same cycle.
- **instr changes:** changes on instr while EXEC && !last are ignored.
- **Invariant:** beat_valid=0 ⇒ v_en=s_en=first=last=0, lane=0.

Test Plan:
- Reset then VADD 0x0A4A (dst 5, a1 1, a2 1) → next cycle beat_valid=1, v_en=1, dstAddr=5, addr1=1, addr2=1, first=1. Then 16 beats lane 0..15, last at lane 15, then IDLE with instr_ready=1.
- VLD 0x4C87 → 17 beats; offset=7, addr1=2, dstAddr=6; last at lane 16; instr_ready=0 during lanes 0..15.
- SLL 0x6A5C held valid, followed by SLH 0x7AFF → beats are 1 cycle each and back-to-back. immediate is 0x5C, then 0xFF; first=last=1 both cycles; no idle gap.
- VST with a second instr_valid asserted mid-op → second instr not accepted until the last beat; accepted on the last beat and begins the next cycle.
- rst pulsed at lane 7 of VDOT → next cycle all outputs 0, instr_ready=1; a subsequent VADD starts at lane 0.
- Opcode 0x9xxx and 0xFxxx → 1 beat, beat_valid=1, v_en=s_en=0, all other fields 0. Repeat with VLEN=4 to check 4/5-beat counts and LW=3.

Source files
------------

// File: rtl/decode_sequencer.sv
// decode_sequencer: accepts one 16-bit instruction per valid/ready handshake,
// registers its decoded fields, then walks the op one lane per cycle. The lane
// index and the first/last markers are driven to the vector/scalar datapath.
module decode_sequencer #(
    parameter int VLEN  = 16,  // beats per vector op (must be >= 2)
    parameter int RAW   = 3,   // register address width
    parameter int OFF_W = 6,   // memory offset field width
    parameter int IMM_W = 8    // scalar immediate field width
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_valid,
    input  logic [15:0]                instr,
    output logic                       instr_ready,
    output logic                       beat_valid,
    output logic [3:0]                 functype,
    output logic                       v_en,
    output logic                       s_en,
    output logic [RAW-1:0]             addr1,
    output logic [RAW-1:0]             addr2,
    output logic [RAW-1:0]             dstAddr,
    output logic [OFF_W-1:0]           offset,
    output logic [IMM_W-1:0]           immediate,
    output logic [$clog2(VLEN+1)-1:0]  lane,
    output logic                       first,
    output logic                       last,
    output logic                       busy
);

    localparam int LW = $clog2(VLEN+1);

    // Register fields sit just below the opcode: dst, src1, src2 from the top.
    localparam int DST_HI = 3*RAW + 2;
    localparam int A1_HI  = 2*RAW + 2;
    localparam int A2_HI  = RAW + 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_SST  = 4'b0011;
    localparam logic [3:0] OP_VLD  = 4'b0100;
    localparam logic [3:0] OP_VST  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SLH  = 4'b0111;

    // Beat totals are stored as the index of the final lane.
    localparam logic [LW-1:0] LAST_ONE  = '0;
    localparam logic [LW-1:0] LAST_VEC  = LW'(VLEN - 1);
    localparam logic [LW-1:0] LAST_VLD  = LW'(VLEN);

    logic [0:0]        state_q, state_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [LW-1:0]     last_lane_q, last_lane_d;
    logic [3:0]        functype_q, functype_d;
    logic              v_en_q, v_en_d;
    logic              s_en_q, s_en_d;
    logic [RAW-1:0]    addr1_q, addr1_d;
    logic [RAW-1:0]    addr2_q, addr2_d;
    logic [RAW-1:0]    dst_q, dst_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [IMM_W-1:0]  imm_q, imm_d;

    logic              exec;
    logic              at_last;
    logic              accept;

    logic [3:0]        dec_functype;
    logic              dec_v_en, dec_s_en;
    logic [RAW-1:0]    dec_addr1, dec_addr2, dec_dst;
    logic [OFF_W-1:0]  dec_offset;
    logic [IMM_W-1:0]  dec_imm;
    logic [LW-1:0]     dec_last_lane;

    assign exec    = (state_q == S_EXEC);
    assign at_last = exec && (lane_q == last_lane_q);
    assign accept  = instr_valid && instr_ready;

    // Decode the offered instruction; fields an opcode does not use stay zero.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        dec_functype  = instr[15:12];
        dec_v_en      = 1'b0;
        dec_s_en      = 1'b0;
        dec_addr1     = '0;
        dec_addr2     = '0;
        dec_dst       = '0;
        dec_offset    = '0;
        dec_imm       = '0;
        dec_last_lane = LAST_ONE;
        case (instr[15:12])
            OP_VADD, OP_VDOT, OP_SMUL: begin
                dec_v_en      = 1'b1;
                dec_s_en      = (instr[15:12] != OP_VADD);
                dec_addr1     = instr[A1_HI -: RAW];
                dec_addr2     = instr[A2_HI -: RAW];
                dec_dst       = instr[DST_HI -: RAW];
                dec_last_lane = LAST_VEC;
            end
            OP_SST: begin
                dec_s_en   = 1'b1;
                dec_addr1  = instr[A1_HI -: RAW];
                dec_dst    = instr[DST_HI -: RAW];
                dec_offset = instr[OFF_W-1:0];
            end
            OP_VLD, OP_VST: begin
                dec_v_en      = 1'b1;
                dec_addr1     = instr[A1_HI -: RAW];
                dec_dst       = instr[DST_HI -: RAW];
                dec_offset    = instr[OFF_W-1:0];
                // The load carries one extra beat to cover memory read latency.
                dec_last_lane = (instr[15:12] == OP_VLD) ? LAST_VLD : LAST_VEC;
            end
            OP_SLL, OP_SLH: begin
                dec_s_en  = 1'b1;
                dec_addr1 = instr[DST_HI -: RAW];
                dec_dst   = instr[DST_HI -: RAW];
                dec_imm   = instr[IMM_W-1:0];
            end
            default: begin
                // NOP and undefined opcodes: a single beat showing only functype.
            end
        endcase
    end

    // Sequencer next state: load on accept, advance the lane, drop to idle after the last beat.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        last_lane_d = last_lane_q;
        functype_d  = functype_q;
        v_en_d      = v_en_q;
        s_en_d      = s_en_q;
        addr1_d     = addr1_q;
        addr2_d     = addr2_q;
        dst_d       = dst_q;
        offset_d    = offset_q;
        imm_d       = imm_q;
        if (accept) begin
            state_d     = S_EXEC;
            lane_d      = '0;
            last_lane_d = dec_last_lane;
            functype_d  = dec_functype;
            v_en_d      = dec_v_en;
            s_en_d      = dec_s_en;
            addr1_d     = dec_addr1;
            addr2_d     = dec_addr2;
            dst_d       = dec_dst;
            offset_d    = dec_offset;
            imm_d       = dec_imm;
        end else if (at_last) begin
            state_d = S_IDLE;
            lane_d  = '0;
        end else if (exec) begin
            lane_d = lane_q + LW'(1);
        end
    end

    // State and field registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            // NOTE: every flop here is reset; the array is small and idle outputs must read zero.
            state_q     <= S_IDLE;
            lane_q      <= '0;
            last_lane_q <= '0;
            functype_q  <= '0;
            v_en_q      <= 1'b0;
            s_en_q      <= 1'b0;
            addr1_q     <= '0;
            addr2_q     <= '0;
            dst_q       <= '0;
            offset_q    <= '0;
            imm_q       <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            last_lane_q <= last_lane_d;
            functype_q  <= functype_d;
            v_en_q      <= v_en_d;
            s_en_q      <= s_en_d;
            addr1_q     <= addr1_d;
            addr2_q     <= addr2_d;
            dst_q       <= dst_d;
            offset_q    <= offset_d;
            imm_q       <= imm_d;
        end
    end

    // Outputs: registered fields are shown only while a beat is active.
    always_comb begin
        busy        = exec;
        beat_valid  = exec;
        instr_ready = !exec || at_last;
        functype    = exec ? functype_q : '0;
        v_en        = exec && v_en_q;
        s_en        = exec && s_en_q;
        addr1       = exec ? addr1_q : '0;
        addr2       = exec ? addr2_q : '0;
        dstAddr     = exec ? dst_q : '0;
        offset      = exec ? offset_q : '0;
        immediate   = exec ? imm_q : '0;
        lane        = exec ? lane_q : '0;
        first       = exec && (lane_q == '0);
        last        = at_last;
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// Testbench for decode_sequencer: table-driven vectors, hand-written multi-cycle
// sequences and random traffic, all checked against a queue-of-beats model.
module tb_decode_sequencer;

    typedef struct packed {
        logic [3:0] ft;
        logic       v_en;
        logic       s_en;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [2:0] dst;
        logic [5:0] off;
        logic [7:0] imm;
        logic [4:0] beats;
    } op_t;

    typedef struct {
        logic [15:0] instr;
        op_t         exp;
    } vec_t;

    typedef struct {
        op_t f;
        int  lane;
        bit  first;
        bit  last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready, beat_valid, v_en, s_en, first, last, busy;
    logic [3:0]  functype;
    logic [2:0]  addr1, addr2, dstAddr;
    logic [5:0]  offset;
    logic [7:0]  immediate;
    logic [4:0]  lane;

    logic        instr_valid4;
    logic [15:0] instr4;
    logic        instr_ready4, beat_valid4, v_en4, s_en4, first4, last4, busy4;
    logic [3:0]  functype4;
    logic [2:0]  addr1_4, addr2_4, dst4;
    logic [5:0]  offset4;
    logic [7:0]  imm4;
    logic [2:0]  lane4;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    string phase  = "reset";
    beat_t exp_q[$];
    vec_t  tbl[10];

    always #5 clk = ~clk;

    decode_sequencer #(.VLEN(16)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .beat_valid(beat_valid), .functype(functype),
        .v_en(v_en), .s_en(s_en), .addr1(addr1), .addr2(addr2), .dstAddr(dstAddr),
        .offset(offset), .immediate(immediate), .lane(lane), .first(first),
        .last(last), .busy(busy)
    );

    decode_sequencer #(.VLEN(4)) dut4 (
        .clk(clk), .rst(rst), .instr_valid(instr_valid4), .instr(instr4),
        .instr_ready(instr_ready4), .beat_valid(beat_valid4), .functype(functype4),
        .v_en(v_en4), .s_en(s_en4), .addr1(addr1_4), .addr2(addr2_4), .dstAddr(dst4),
        .offset(offset4), .immediate(imm4), .lane(lane4), .first(first4),
        .last(last4), .busy(busy4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic [3:0] ft, input logic ve, input logic se,
                               input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] dst,
                               input logic [5:0] off, input logic [7:0] imm, input int n);
        op_t o;
        o.ft = ft; o.v_en = ve; o.s_en = se; o.a1 = a1; o.a2 = a2; o.dst = dst;
        o.off = off; o.imm = imm; o.beats = 5'(n);
        return o;
    endfunction

    // Reference decode written straight from the opcode table.
    function automatic op_t decode_ref(input logic [15:0] w);
        logic [2:0] d, s1, s2;
        d  = w[11:9];
        s1 = w[8:6];
        s2 = w[5:3];
        case (w[15:12])
            4'h0:    return mk(4'h0, 1, 0, s1, s2, d, 0, 0, 16);
            4'h1:    return mk(4'h1, 1, 1, s1, s2, d, 0, 0, 16);
            4'h2:    return mk(4'h2, 1, 1, s1, s2, d, 0, 0, 16);
            4'h3:    return mk(4'h3, 0, 1, s1, 0, d, w[5:0], 0, 1);
            4'h4:    return mk(4'h4, 1, 0, s1, 0, d, w[5:0], 0, 17);
            4'h5:    return mk(4'h5, 1, 0, s1, 0, d, w[5:0], 0, 16);
            4'h6:    return mk(4'h6, 0, 1, d, 0, d, 0, w[7:0], 1);
            4'h7:    return mk(4'h7, 0, 1, d, 0, d, 0, w[7:0], 1);
            default: return mk(w[15:12], 0, 0, 0, 0, 0, 0, 0, 1);
        endcase
    endfunction

    function automatic logic [63:0] act_vec();
        return {25'd0, instr_ready, beat_valid, functype, v_en, s_en, addr1, addr2,
                dstAddr, offset, immediate, lane, first, last, busy};
    endfunction

    // One clock of the main DUT: compare against the model head, then drive the next inputs.
    task automatic step(input logic r, input logic v, input logic [15:0] ins, input op_t f);
        logic        exp_ready;
        logic [63:0] exp;
        beat_t       b;
        @(negedge clk);
        cyc++;
        exp_ready = (exp_q.size() <= 1);
        if (exp_q.size() == 0) begin
            exp = {25'd0, 1'b1, 38'd0};
        end else begin
            b   = exp_q[0];
            exp = {25'd0, exp_ready, 1'b1, b.f.ft, b.f.v_en, b.f.s_en, b.f.a1, b.f.a2,
                   b.f.dst, b.f.off, b.f.imm, 5'(b.lane), b.first, b.last, 1'b1};
            void'(exp_q.pop_front());
        end
        check($sformatf("%s cyc%0d", phase, cyc), act_vec(), exp);
        if (r) begin
            exp_q.delete();
        end else if (v && exp_ready) begin
            for (int i = 0; i < int'(f.beats); i++)
                exp_q.push_back('{f: f, lane: i, first: (i == 0), last: (i == int'(f.beats) - 1)});
        end
        rst         = r;
        instr_valid = v;
        instr       = ins;
    endtask

    task automatic ref_step(input logic r, input logic v, input logic [15:0] ins);
        step(r, v, ins, decode_ref(ins));
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() > 0; k++)
            ref_step(0, 0, 16'h0000);
        ref_step(0, 0, 16'h0000);
    endtask

    // Short-vector instance: expects n beats with lanes 0..n-1 and then idle.
    task automatic run4(input logic [15:0] ins, input int n);
        @(negedge clk);
        instr_valid4 = 1'b1;
        instr4       = ins;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instr_valid4 = 1'b0;
            check($sformatf("vlen4 %h beat%0d", ins, i),
                  {58'd0, beat_valid4, lane4, first4, last4, instr_ready4},
                  {58'd0, 1'b1, 3'(i), (i == 0), (i == n - 1), (i == n - 1)});
        end
        @(negedge clk);
        check($sformatf("vlen4 %h idle", ins),
              {58'd0, beat_valid4, lane4, first4, last4, instr_ready4},
              {58'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1});
    endtask

    initial begin
        tbl[0] = '{16'h0A4A, mk(4'h0, 1, 0, 1, 1, 5, 6'h00, 8'h00, 16)};
        tbl[1] = '{16'h4C87, mk(4'h4, 1, 0, 2, 0, 6, 6'h07, 8'h00, 17)};
        tbl[2] = '{16'h6A5C, mk(4'h6, 0, 1, 5, 0, 5, 6'h00, 8'h5C, 1)};
        tbl[3] = '{16'h7AFF, mk(4'h7, 0, 1, 5, 0, 5, 6'h00, 8'hFF, 1)};
        tbl[4] = '{16'h1A4A, mk(4'h1, 1, 1, 1, 1, 5, 6'h00, 8'h00, 16)};
        tbl[5] = '{16'h2D13, mk(4'h2, 1, 1, 4, 2, 6, 6'h00, 8'h00, 16)};
        tbl[6] = '{16'h3E3F, mk(4'h3, 0, 1, 0, 0, 7, 6'h3F, 8'h00, 1)};
        tbl[7] = '{16'h5256, mk(4'h5, 1, 0, 1, 0, 1, 6'h16, 8'h00, 16)};
        tbl[8] = '{16'h9ABC, mk(4'h9, 0, 0, 0, 0, 0, 6'h00, 8'h00, 1)};
        tbl[9] = '{16'hFFFF, mk(4'hF, 0, 0, 0, 0, 0, 6'h00, 8'h00, 1)};

        rst          = 1'b1;
        instr_valid  = 1'b0;
        instr        = 16'h0000;
        instr_valid4 = 1'b0;
        instr4       = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        phase = "table";
        for (int i = 0; i < 10; i++) begin
            step(0, 1, tbl[i].instr, tbl[i].exp);
            for (int k = 0; k < int'(tbl[i].exp.beats); k++)
                step(0, 0, 16'h0000, tbl[i].exp);
            step(0, 0, 16'h0000, tbl[i].exp);
        end

        phase = "sll_slh";
        ref_step(0, 1, 16'h6A5C);
        ref_step(0, 1, 16'h7AFF);
        ref_step(0, 0, 16'h0000);
        drain();

        phase = "vst_midop";
        ref_step(0, 1, 16'h5256);
        for (int k = 0; k < 17; k++)
            ref_step(0, 1, (k < 15) ? 16'($urandom) : 16'h0A4A);
        drain();

        phase = "rst_lane7";
        ref_step(0, 1, 16'h1A4A);
        for (int k = 0; k < 7; k++)
            ref_step(0, 0, 16'h0000);
        ref_step(1, 0, 16'h0000);
        ref_step(0, 0, 16'h0000);
        ref_step(0, 1, 16'h0A4A);
        drain();

        phase = "random";
        for (int k = 0; k < 600; k++)
            ref_step(0, ($urandom_range(0, 1) == 1), 16'($urandom));
        drain();

        phase = "vlen4";
        run4(16'h0A4A, 4);
        run4(16'h4C87, 5);
        run4(16'h9123, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
